// File: rtl/pic_init_sequencer.sv
// pic_init_sequencer: drives the 8259-style PIC init writes (ICW1..ICW4, OCW1),
// then arbitrates host OCW writes onto the same strobes and data bus.
// Ports: clk, reset_n (sync, active-low), start, ocw_request/select/data in;
//   ocw_grant, illegal_request, busy, done, five write strobes and
//   internal_data_bus out. All outputs are registered.
// Build option: define PIC_SEQ_DEFAULT_OCW3_EN to append an OCW3 write (8'h0A)
//   after OCW1 in the init sequence.
module pic_init_sequencer #(
  parameter logic        SINGLE      = 1'b1,
  parameter logic        LTIM        = 1'b0,
  parameter logic        SET_ICW4    = 1'b1,
  parameter logic        AEOI        = 1'b0,
  parameter logic [4:0]  VECTOR_BASE = 5'h08,
  parameter logic [7:0]  CASCADE_CFG = 8'h00,
  parameter logic [7:0]  IMR_INIT    = 8'hFF,
  parameter int unsigned WRITE_GAP   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       ocw_request,
  input  logic [1:0] ocw_select,
  input  logic [7:0] ocw_data,
  output logic       ocw_grant,
  output logic       illegal_request,
  output logic       busy,
  output logic       done,
  output logic       write_initial_command_word_1_reset,
  output logic       write_initial_command_word_2_4,
  output logic       write_operation_control_word_1,
  output logic       write_operation_control_word_2,
  output logic       write_operation_control_word_3,
  output logic [7:0] internal_data_bus
);

  typedef enum logic [3:0] {
    IDLE, ICW1, ICW2, ICW3, ICW4, OCW1,
`ifdef PIC_SEQ_DEFAULT_OCW3_EN
    OCW3I,
`endif
    GAP, READY, OCWW
  } state_e;

  localparam logic [3:0] GAP_LD =
    (WRITE_GAP == 0) ? 4'd0 : 4'(WRITE_GAP - 1);

  localparam logic [7:0] ICW1_DATA =
    {3'b000, 1'b1, LTIM, 1'b0, SINGLE, SET_ICW4};
  localparam logic [7:0] ICW2_DATA = {VECTOR_BASE, 3'b000};
  localparam logic [7:0] ICW4_DATA = {6'b0, AEOI, 1'b1};

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  logic [3:0] cnt_q, cnt_d;

  logic       w1_q, w1_d;
  logic       w24_q, w24_d;
  logic       o1_q, o1_d;
  logic       o2_q, o2_d;
  logic       o3_q, o3_d;
  logic       grant_q, grant_d;
  logic       ill_q, ill_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] bus_q, bus_d;

  // Write that follows the one just issued; READY ends any write chain.
  function automatic state_e next_write(input state_e s);
    case (s)
      ICW1:    next_write = ICW2;
      ICW2:    next_write = !SINGLE ? ICW3 : (SET_ICW4 ? ICW4 : OCW1);
      ICW3:    next_write = SET_ICW4 ? ICW4 : OCW1;
      ICW4:    next_write = OCW1;
`ifdef PIC_SEQ_DEFAULT_OCW3_EN
      OCW1:    next_write = OCW3I;
`endif
      default: next_write = READY;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = ICW1;
      end
      READY: begin
        // start outranks a pending OCW request
        if (start)            state_d = ICW1;
        else if (ocw_request) state_d = OCWW;
      end
      GAP: begin
        if (cnt_q == 4'd0) state_d = ret_q;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: begin
        if (WRITE_GAP == 0) begin
          state_d = next_write(state_q);
        end else begin
          state_d = GAP;
          ret_d   = next_write(state_q);
          cnt_d   = GAP_LD;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_comb begin
    logic is_ocww;
    is_ocww = (state_d == OCWW);
    w1_d    = (state_d == ICW1);
    w24_d   = state_d inside {ICW2, ICW3, ICW4};
    o1_d    = (state_d == OCW1) || (is_ocww && ocw_select == 2'd1);
    o2_d    = is_ocww && ocw_select == 2'd2;
    o3_d    = is_ocww && ocw_select == 2'd3;
`ifdef PIC_SEQ_DEFAULT_OCW3_EN
    o3_d    = o3_d || (state_d == OCW3I);
`endif
    grant_d = is_ocww;
    ill_d   = is_ocww && ocw_select == 2'd0;
    busy_d  = !(state_d inside {IDLE, READY});
    // A gap keeps done only when it follows a host OCW write.
    done_d  = (state_d == READY) || is_ocww ||
              (state_d == GAP && done_q);
    bus_d   = 8'h00;
    case (state_d)
      ICW1: bus_d = ICW1_DATA;
      ICW2: bus_d = ICW2_DATA;
      ICW3: bus_d = CASCADE_CFG;
      ICW4: bus_d = ICW4_DATA;
      OCW1: bus_d = IMR_INIT;
`ifdef PIC_SEQ_DEFAULT_OCW3_EN
      OCW3I: bus_d = 8'h0A;
`endif
      OCWW: bus_d = (ocw_select != 2'd0) ? ocw_data : 8'h00;
      default: bus_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      cnt_q   <= 4'd0;
      w1_q    <= 1'b0;
      w24_q   <= 1'b0;
      o1_q    <= 1'b0;
      o2_q    <= 1'b0;
      o3_q    <= 1'b0;
      grant_q <= 1'b0;
      ill_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bus_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      w1_q    <= w1_d;
      w24_q   <= w24_d;
      o1_q    <= o1_d;
      o2_q    <= o2_d;
      o3_q    <= o3_d;
      grant_q <= grant_d;
      ill_q   <= ill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bus_q   <= bus_d;
    end
  end

  assign write_initial_command_word_1_reset = w1_q;
  assign write_initial_command_word_2_4     = w24_q;
  assign write_operation_control_word_1     = o1_q;
  assign write_operation_control_word_2     = o2_q;
  assign write_operation_control_word_3     = o3_q;
  assign ocw_grant                          = grant_q;
  assign illegal_request                    = ill_q;
  assign busy                               = busy_q;
  assign done                               = done_q;
  assign internal_data_bus                  = bus_q;

endmodule
